// File: rtl/oloc_writeback_if.sv
// -----------------------------------------------------------------------------
// oloc_writeback_if
// Bundles the result-capture and memory-arbiter signals of oloc_writeback.
//   slave  : the writeback stage's view (takes results and grant, drives the
//            arbiter request and the data-memory write port)
//   master : the surrounding system's view (R-calc stage, arbiter, memory)
//
// Handshakes:
//   * write_to_oloc is a one-cycle valid strobe with no back-pressure. The
//     result is either queued or, when the queue is full and nothing drains
//     in that cycle, dropped and flagged.
//   * memory_rqt_wb / grant_wb is request/grant. A word moves to memory on
//     every cycle where the stage is in its write phase, grant_wb is high and
//     an entry is queued. The write appears on dmem_wr_* one cycle later. A
//     grant with no request pending has no effect.
// -----------------------------------------------------------------------------
interface oloc_writeback_if #(
  parameter int RES_W  = 64,
  parameter int OUT_W  = 32,
  parameter int ADDR_W = 17
);
  logic              write_to_oloc;
  logic [RES_W-1:0]  rcal_result;
  logic [ADDR_W-1:0] outputloc;
  logic              done_layer_in;
  logic              grant_wb;
  logic              memory_rqt_wb;
  logic              dmem_wr_en;
  logic [ADDR_W-1:0] dmem_wr_addr;
  logic [OUT_W-1:0]  dmem_wr_data;

  modport slave (
    input  write_to_oloc, rcal_result, outputloc, done_layer_in, grant_wb,
    output memory_rqt_wb, dmem_wr_en, dmem_wr_addr, dmem_wr_data
  );

  modport master (
    output write_to_oloc, rcal_result, outputloc, done_layer_in, grant_wb,
    input  memory_rqt_wb, dmem_wr_en, dmem_wr_addr, dmem_wr_data
  );
endinterface

// File: rtl/oloc_writeback.sv
// -----------------------------------------------------------------------------
// oloc_writeback
// Stage after the R-calculation stage. It rescales and saturates each 64-bit
// fixed-point result to the memory word width and queues it with its output
// location. It drains the queue into data memory through the arbiter, and it
// pulses layer_done once every result of a layer has been written.
//
// Ports:
//   clk, reset  : clock; asynchronous active-high reset
//   bus         : oloc_writeback_if.slave (results in, arbiter + memory out)
//   fifo_level  : entries currently queued
//   overflow    : sticky, a result was dropped on a full queue
//   layer_done  : one-cycle pulse, layer fully committed to memory
//   fsm_state   : current drain FSM state (0 IDLE, 1 REQ, 2 WRITE)
// -----------------------------------------------------------------------------
module oloc_writeback #(
  parameter int DEPTH      = 8,
  parameter int RES_W      = 64,
  parameter int OUT_W      = 32,
  parameter int FRAC_SHIFT = 28,
  parameter int ADDR_W     = 17
) (
  input  logic                     clk,
  input  logic                     reset,
  oloc_writeback_if.slave          bus,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic                     layer_done,
  output logic [1:0]               fsm_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + OUT_W;

  // Saturation bounds of the output word, sign-extended to the result width.
  localparam logic signed [RES_W-1:0] SAT_MAX =
    {{(RES_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RES_W-1:0] SAT_MIN =
    {{(RES_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [ENT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level, level_next;
  logic              full, empty, push, pop, drop;
  logic              pending_done, pend_eff, fire;
  logic              rqt_q, wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [OUT_W-1:0]  wr_data_q;
  logic signed [RES_W-1:0] shifted;
  logic [OUT_W-1:0]  conv_data;

  // Rescale then clamp into the signed output word range.
  always_comb begin
    shifted = $signed(bus.rcal_result) >>> FRAC_SHIFT;
    if (shifted > SAT_MAX) begin
      conv_data = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      conv_data = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      conv_data = shifted[OUT_W-1:0];
    end
  end

  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);
  assign pop   = (state == WRITE) && bus.grant_wb && !empty;
  // A full queue still accepts a result when the head leaves in the same cycle.
  assign push  = bus.write_to_oloc && (!full || pop);
  assign drop  = bus.write_to_oloc && full && !pop;
  assign level_next = level + LVL_W'(push) - LVL_W'(pop);

  // Layer closes when nothing is queued after this edge and no write will be
  // on the memory port; a done marker arriving with a push waits for that push.
  assign pend_eff = pending_done || bus.done_layer_in;
  assign fire     = pend_eff && (level_next == '0) && !pop;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!empty) state_next = REQ;
      REQ:     if (bus.grant_wb) state_next = WRITE;
      // Leaving on a lost grant keeps the head queued; it is retried via REQ.
      WRITE:   if (!pop || (level_next == '0)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      overflow     <= 1'b0;
      rqt_q        <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      pending_done <= 1'b0;
      layer_done   <= 1'b0;
    end else begin
      state        <= state_next;
      rqt_q        <= (state_next != IDLE);
      level        <= level_next;
      wr_en_q      <= pop;
      pending_done <= pend_eff && !fire;
      layer_done   <= fire;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr                 <= rd_ptr + PTR_W'(1);
        {wr_addr_q, wr_data_q} <= mem[rd_ptr];
      end
      if (drop) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.outputloc, conv_data};
  end

  assign bus.memory_rqt_wb = rqt_q;
  assign bus.dmem_wr_en    = wr_en_q;
  assign bus.dmem_wr_addr  = wr_addr_q;
  assign bus.dmem_wr_data  = wr_data_q;
  assign fifo_level        = level;
  assign fsm_state         = state;

endmodule

// File: tb/tb_oloc_writeback.sv
module tb_oloc_writeback;
  localparam int DEPTH  = 8;
  localparam int RES_W  = 64;
  localparam int OUT_W  = 32;
  localparam int FSH    = 28;
  localparam int ADDR_W = 17;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  oloc_writeback_if #(.RES_W(RES_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) bus ();
  logic [LVL_W-1:0] fifo_level;
  logic             overflow;
  logic             layer_done;
  logic [1:0]       fsm_state;

  oloc_writeback #(
    .DEPTH(DEPTH), .RES_W(RES_W), .OUT_W(OUT_W), .FRAC_SHIFT(FSH), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave),
    .fifo_level(fifo_level),
    .overflow(overflow),
    .layer_done(layer_done),
    .fsm_state(fsm_state)
  );

  // ---------------- scoreboard state ----------------
  logic [ADDR_W+OUT_W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int wr_count = 0;
  int ld_count = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  int last_ld_cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Independent reference of the rescale + saturate rule.
  function automatic logic [31:0] conv(input logic [63:0] r);
    logic signed [63:0] s;
    s = $signed(r) >>> FSH;
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return s[31:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every memory write must match the head of the expected queue.
  always @(negedge clk) begin
    logic [ADDR_W+OUT_W-1:0] e;
    if (bus.dmem_wr_en === 1'b1) begin
      wr_count++;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("spurious_write", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", bus.dmem_wr_addr, e[ADDR_W+OUT_W-1:OUT_W]);
        check("wr_data", bus.dmem_wr_data, e[OUT_W-1:0]);
      end
    end
    if (layer_done === 1'b1) begin
      ld_count++;
      last_ld_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] res, input logic [ADDR_W-1:0] addr,
                      input logic done, input logic [31:0] exp_data, input bit keep);
    bus.write_to_oloc = 1'b1;
    bus.rcal_result   = res;
    bus.outputloc     = addr;
    bus.done_layer_in = done;
    if (keep) exp_q.push_back({addr, exp_data});
    tick();
    bus.write_to_oloc = 1'b0;
    bus.done_layer_in = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && fifo_level == 0 && bus.dmem_wr_en == 1'b0) && n < 100) begin
      tick();
      n++;
    end
    check(tag, n < 100, 1);
  endtask

  task automatic wait_writes(input int target, input string tag);
    int n;
    n = 0;
    while (wr_count < target && n < 60) begin
      tick();
      n++;
    end
    check(tag, wr_count, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int base, n;
    logic [63:0] r;
    reset = 1'b1;
    bus.write_to_oloc = 1'b0;
    bus.rcal_result   = '0;
    bus.outputloc     = '0;
    bus.done_layer_in = 1'b0;
    bus.grant_wb      = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_rqt", bus.memory_rqt_wb, 0);
    check("rst_wr_en", bus.dmem_wr_en, 0);
    check("rst_wr_addr", bus.dmem_wr_addr, 0);
    check("rst_wr_data", bus.dmem_wr_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_layer_done", layer_done, 0);
    check("rst_state", fsm_state, 0);
    reset = 1'b0;
    tick();

    // Single result, grant tied high: request, grant, write at push+3
    bus.grant_wb = 1'b1;
    push(64'h0000_0001_2000_0000, 17'h00100, 1'b0, 32'h12, 1'b1);
    check("t1_level", fifo_level, 1);
    check("t1_rqt_early", bus.memory_rqt_wb, 0);
    tick();
    check("t1_rqt", bus.memory_rqt_wb, 1);
    check("t1_state_req", fsm_state, 1);
    tick();
    check("t1_state_write", fsm_state, 2);
    check("t1_no_wr_yet", bus.dmem_wr_en, 0);
    tick();
    check("t1_wr_en", bus.dmem_wr_en, 1);
    check("t1_rqt_fall", bus.memory_rqt_wb, 0);
    tick();
    check("t1_wr_en_off", bus.dmem_wr_en, 0);
    check("t1_addr_hold", bus.dmem_wr_addr, 17'h00100);
    check("t1_no_layer_done", ld_count, 0);

    // Saturation and range boundaries
    push(64'h7FFF_FFFF_FFFF_FFFF, 17'h00001, 1'b0, 32'h7FFF_FFFF, 1'b1);
    push(64'h8000_0000_0000_0000, 17'h00002, 1'b0, 32'h8000_0000, 1'b1);
    push(64'hFFFF_FFFF_F000_0000, 17'h00003, 1'b0, 32'hFFFF_FFFF, 1'b1);
    push(64'h07FF_FFFF_F000_0000, 17'h00004, 1'b0, 32'h7FFF_FFFF, 1'b1);
    push(64'h0800_0000_0000_0000, 17'h00005, 1'b0, 32'h7FFF_FFFF, 1'b1);
    push(64'hF800_0000_0000_0000, 17'h00006, 1'b0, 32'h8000_0000, 1'b1);
    push(64'hF7FF_FFFF_F000_0000, 17'h00007, 1'b0, 32'h8000_0000, 1'b1);
    push(64'h0000_0000_0FFF_FFFF, 17'h00008, 1'b0, 32'h0000_0000, 1'b1);
    wait_drain("sat_drain");

    // Burst with back-pressure and overflow
    bus.grant_wb = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      r = {32'h0, $urandom} << $urandom_range(0, 20);
      push(r, ADDR_W'(17'h200 + i), 1'b0, conv(r), 1'b1);
    end
    check("bp_level_full", fifo_level, DEPTH);
    check("bp_no_overflow", overflow, 0);
    push(64'h0000_0005_0000_0000, 17'h1FFFF, 1'b0, 32'h50, 1'b0);
    check("bp_overflow", overflow, 1);
    check("bp_level_held", fifo_level, DEPTH);
    base = wr_count;
    bus.grant_wb = 1'b1;
    n = 0;
    while (bus.dmem_wr_en !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("bp_first_write", bus.dmem_wr_en, 1);
    for (int i = 1; i < DEPTH; i++) begin
      tick();
      check("bp_back_to_back", bus.dmem_wr_en, 1);
    end
    check("bp_rqt_fall", bus.memory_rqt_wb, 0);
    tick();
    check("bp_wr_count", wr_count - base, DEPTH);
    check("bp_q_empty", exp_q.size(), 0);
    check("bp_overflow_sticky", overflow, 1);

    // Grant interruption: 2 writes, gap, 2 writes
    bus.grant_wb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r = {32'h0, $urandom};
      push(r, ADDR_W'(17'h300 + i), 1'b0, conv(r), 1'b1);
    end
    base = wr_count;
    bus.grant_wb = 1'b1;
    wait_writes(base + 2, "gi_first_two");
    bus.grant_wb = 1'b0;
    repeat (3) tick();
    check("gi_gap_no_write", wr_count, base + 2);
    check("gi_level_kept", fifo_level, 2);
    bus.grant_wb = 1'b1;
    wait_writes(base + 4, "gi_last_two");
    wait_drain("gi_drain");

    // Layer done coincident with the 3rd push
    base = ld_count;
    for (int i = 0; i < 3; i++) begin
      r = {32'h0, $urandom};
      push(r, ADDR_W'(17'h400 + i), (i == 2), conv(r), 1'b1);
    end
    wait_drain("ld_drain");
    repeat (3) tick();
    check("ld_one_pulse", ld_count, base + 1);
    check("ld_after_last_write", last_ld_cyc, last_wr_cyc + 1);
    bus.done_layer_in = 1'b1;
    tick();
    bus.done_layer_in = 1'b0;
    check("ld_empty_pulse", layer_done, 1);
    tick();
    check("ld_empty_pulse_len", layer_done, 0);
    check("ld_count2", ld_count, base + 2);

    // Repeated done marker before completion yields one pulse
    bus.grant_wb = 1'b0;
    base = ld_count;
    push(64'h0000_0003_0000_0000, 17'h00500, 1'b1, 32'h30, 1'b1);
    bus.done_layer_in = 1'b1;
    tick();
    bus.done_layer_in = 1'b0;
    repeat (2) tick();
    check("ld_wait_no_pulse", ld_count, base);
    bus.grant_wb = 1'b1;
    wait_drain("ld2_drain");
    repeat (3) tick();
    check("ld_absorbed", ld_count, base + 1);

    // Random bursts, random grant, each burst below queue depth
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 6; i++) begin
        bus.grant_wb = 1'($urandom_range(0, 1));
        r = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 1) r = {{20{r[43]}}, r[43:0]};
        push(r, ADDR_W'($urandom_range(0, 131071)), 1'b0, conv(r), 1'b1);
      end
      bus.grant_wb = 1'b1;
      wait_drain("rand_drain");
    end

    // Reset in the middle of a burst
    bus.grant_wb = 1'b0;
    for (int i = 0; i < 5; i++) begin
      r = {32'h0, $urandom};
      push(r, ADDR_W'(17'h600 + i), 1'b0, conv(r), 1'b1);
    end
    bus.grant_wb = 1'b1;
    n = 0;
    while (fsm_state != 2'd2 && n < 10) begin
      tick();
      n++;
    end
    check("mr_in_write", fsm_state, 2);
    check("mr_level5", fifo_level, 5);
    base = wr_count;
    reset = 1'b1;
    #1;
    check("mr_rqt", bus.memory_rqt_wb, 0);
    check("mr_wr_en", bus.dmem_wr_en, 0);
    check("mr_wr_addr", bus.dmem_wr_addr, 0);
    check("mr_wr_data", bus.dmem_wr_data, 0);
    check("mr_level", fifo_level, 0);
    check("mr_overflow", overflow, 0);
    check("mr_state", fsm_state, 0);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
    repeat (10) tick();
    check("mr_no_writes", wr_count, base);
    check("mr_level_after", fifo_level, 0);
    check("mr_rqt_after", bus.memory_rqt_wb, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
